// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the two-requester SD sector-read arbiter.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam int          SD_ADDR_W       = 32;
  localparam int          SD_DATA_W       = 8;
  localparam logic [31:0] TIMEOUT_CYC_DEF = 32'd2_000_000;

endpackage

// File: rtl/sd_arb_watchdog.sv
// Open-read watchdog: counts cycles while run is high, expire pulses on the last allowed cycle.
module sd_arb_watchdog
  import sd_arb_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expire
);

  logic [31:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 32'd1;
    end else begin
      cnt <= '0;
    end
  end

  assign expire = run && (cnt == TIMEOUT_CYC - 32'd1);

endmodule

// File: rtl/sd_sec_read_arb.sv
// Round-robin arbiter sharing one SD sector-read port between two requesters.
// Optional read watchdog enabled with macro SD_ARB_TIMEOUT_EN.
module sd_sec_read_arb
  import sd_arb_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sd_init_done,
  input  logic                 req0_sec_read,
  input  logic [SD_ADDR_W-1:0] req0_sec_read_addr,
  output logic [SD_DATA_W-1:0] req0_sec_read_data,
  output logic                 req0_sec_read_data_valid,
  output logic                 req0_sec_read_end,
  input  logic                 req1_sec_read,
  input  logic [SD_ADDR_W-1:0] req1_sec_read_addr,
  output logic [SD_DATA_W-1:0] req1_sec_read_data,
  output logic                 req1_sec_read_data_valid,
  output logic                 req1_sec_read_end,
  output logic                 sd_sec_read,
  output logic [SD_ADDR_W-1:0] sd_sec_read_addr,
  input  logic [SD_DATA_W-1:0] sd_sec_read_data,
  input  logic                 sd_sec_read_data_valid,
  input  logic                 sd_sec_read_end,
  output logic [1:0]           grant,
  output logic                 timeout_err
);

  arb_state_e state, state_nxt;
  logic       owner;       // 0 = requester 0 holds the port
  logic       last_grant;  // requester granted most recently
  logic       pick;
  logic       expire;
  logic       done;

`ifdef SD_ARB_TIMEOUT_EN
  sd_arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .run    (state == ST_ACTIVE),
    .expire (expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign expire         = 1'b0;
`endif

  assign done = sd_sec_read_end || expire;
  // On a tie the requester not served last wins; a lone request always wins.
  assign pick = (req0_sec_read && req1_sec_read) ? ~last_grant : req1_sec_read;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      owner            <= 1'b0;
      last_grant       <= 1'b1;
      sd_sec_read_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt == ST_ACTIVE) begin
        owner            <= pick;
        last_grant       <= pick;
        sd_sec_read_addr <= pick ? req1_sec_read_addr : req0_sec_read_addr;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (sd_init_done && (req0_sec_read || req1_sec_read)) state_nxt = ST_ACTIVE;
      ST_ACTIVE:  if (done) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sd_sec_read              = (state == ST_ACTIVE);
    grant                    = 2'b00;
    if (state == ST_ACTIVE) grant = owner ? 2'b10 : 2'b01;
    timeout_err              = expire;
    req0_sec_read_data       = grant[0] ? sd_sec_read_data : '0;
    req0_sec_read_data_valid = grant[0] && sd_sec_read_data_valid;
    req0_sec_read_end        = grant[0] && done;
    req1_sec_read_data       = grant[1] ? sd_sec_read_data : '0;
    req1_sec_read_data_valid = grant[1] && sd_sec_read_data_valid;
    req1_sec_read_end        = grant[1] && done;
  end

endmodule

// File: doc/sd_sec_read_arb.md
SD_SEC_READ_ARB -- requirements
Module: sd_sec_read_arb

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 32'd2_000_000, max cycles a granted sector read may stay open (used only with SD_ARB_TIMEOUT_EN).
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  sole clock, all logic rising-edge.
- rst  in  1  asynchronous active-low reset.
- sd_init_done  in  1  SD controller initialised.
- req0_sec_read  in  1  requester 0 level request, held until req0_sec_read_end.
- req0_sec_read_addr  in  32  requester 0 sector address.
- req0_sec_read_data  out  8  routed read byte.
- req0_sec_read_data_valid  out  1  routed byte strobe.
- req0_sec_read_end  out  1  routed sector-done pulse.
- req1_* (five ports)  as req0_*  requester 1, identical semantics.
- sd_sec_read  out  1  level read command to SD controller.
- sd_sec_read_addr  out  32  sector address to SD controller.
- sd_sec_read_data  in  8  byte from SD controller.
- sd_sec_read_data_valid  in  1  byte strobe from SD controller.
- sd_sec_read_end  in  1  sector-done pulse from SD controller.
- grant  out  2  one-hot owner, bit0 = requester 0; 2'b00 when idle.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Function
REQ-003 State machine SHALL have exactly three states: IDLE, ACTIVE, RELEASE.
REQ-004 IDLE: SHALL leave IDLE only when sd_init_done=1 and at least one request is high; requests SHALL be ignored while sd_init_done=0.
REQ-005 Arbitration: single request wins; on simultaneous requests the requester not granted last SHALL win (round-robin via last_grant register).
REQ-006 IDLE->ACTIVE: grant, sd_sec_read=1 and sd_sec_read_addr (latched from winner) SHALL be registered, valid one cycle after the request is sampled.
REQ-007 ACTIVE: sd_sec_read SHALL stay 1 and sd_sec_read_addr stable until sd_sec_read_end, even if the granted requester drops its request.
REQ-008 Routing (combinational): granted requester gets sd_sec_read_data, _data_valid, _end; non-granted requester outputs SHALL be 0.
REQ-009 ACTIVE->RELEASE on sd_sec_read_end=1; grant SHALL stay asserted in the end cycle so the end pulse is routed.
REQ-010 RELEASE: exactly one cycle, sd_sec_read=0, grant=2'b00, requests ignored; then IDLE.
REQ-011 Requesters SHALL deassert within one cycle of their _end pulse; a request still high in IDLE is a new request.
REQ-012 Minimum gap between two consecutive sd_sec_read assertions SHALL be 2 cycles (RELEASE + IDLE).
REQ-013 last_grant SHALL update on every IDLE->ACTIVE transition.

Reset
REQ-014 rst=0 SHALL asynchronously force IDLE, sd_sec_read=0, sd_sec_read_addr=0, grant=2'b00, timeout_err=0, watchdog count=0.
REQ-015 last_grant SHALL reset to requester 1 so requester 0 wins the first tie.
REQ-016 Reset mid-ACTIVE SHALL drop sd_sec_read immediately; any in-flight bytes after release are routed to no one.

Configuration
REQ-017 Macro SD_ARB_TIMEOUT_EN defined: counter runs in ACTIVE; reaching TIMEOUT_CYC-1 with no sd_sec_read_end SHALL force RELEASE, pulse timeout_err for one cycle and pulse the granted requester's _end in the same cycle.
REQ-018 Macro undefined: no counter, timeout_err tied to 0, ACTIVE waits indefinitely for sd_sec_read_end.

Structure
REQ-019 Package sd_arb_pkg SHALL hold the state enum, SD_ADDR_W=32, SD_DATA_W=8 and TIMEOUT_CYC default.
REQ-020 Sub-module sd_arb_watchdog (counter + expiry pulse) SHALL be instantiated only under SD_ARB_TIMEOUT_EN.

Verification
REQ-021 Single request: req0 addr 32'h0000_2000 -> sd_sec_read high next cycle, addr 32'h2000, grant=01, 512 valid bytes routed to req0 only, req0_end pulses once.
REQ-022 Tie: req0 and req1 high same cycle after reset -> req0 served first, then req1 (grant 01 then 10), 2-cycle gap between sd_sec_read pulses.
REQ-023 Back-to-back req0 then simultaneous req0+req1 -> req1 wins second arbitration.
REQ-024 sd_init_done=0 with req1 high for 100 cycles -> sd_sec_read stays 0; raise sd_init_done -> grant=10 next cycle.
REQ-025 rst low mid-sector (byte 200) -> sd_sec_read, grant 0 same cycle; after release, no routed valid bytes.
REQ-026 SD_ARB_TIMEOUT_EN, TIMEOUT_CYC=1000, end withheld -> timeout_err and req0_end pulse at ACTIVE cycle 1000, then IDLE; without macro, grant holds.
